uart_tx_arbiter: RTL and testbench

//  Shares the single transmitter of uart_top between N_REQ byte requesters.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus uart_top transmit controls for uart_tx_arbiter.
// master: client/UART side; slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [ID_W-1:0]         grant_id;
    logic                    active;
    logic                    uart_tx_start;
    logic [DATA_W-1:0]       uart_tx_data;
    logic                    uart_busy;
    logic                    timeout_err;

    modport master (
        output req, req_data, uart_busy,
        input  ack, grant_id, active, uart_tx_start, uart_tx_data, timeout_err
    );

    modport slave (
        input  req, req_data, uart_busy,
        output ack, grant_id, active, uart_tx_start, uart_tx_data, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart_top transmitter among N_REQ byte requesters.
// Optional start timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone,
        StAck
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_grant;
    logic [N_REQ-1:0]  r_ack;
    logic              r_active;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_timeout_err;
`endif

    logic              w_found;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_winner;
    logic [DATA_W-1:0] w_winner_data;
    logic [N_REQ-1:0]  w_grant_onehot;

    // Scan from the slot after the last winner so it becomes lowest priority.
    always_comb begin
        w_found       = 1'b0;
        w_idx         = '0;
        w_winner      = '0;
        w_winner_data = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            w_idx = ID_W'((int'(r_ptr) + i) % int'(N_REQ));
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (w_winner == ID_W'(k)) begin
                w_winner_data = bus.req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_ptr      <= ID_W'(N_REQ - 1);
            r_grant    <= '0;
            r_ack      <= '0;
            r_active   <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    // A busy transmitter here belongs to someone else; hold off.
                    if (w_found && !bus.uart_busy) begin
                        r_grant    <= w_winner;
                        r_tx_data  <= w_winner_data;
                        r_active   <= 1'b1;
                        r_tx_start <= 1'b1;
                        r_state    <= StStart;
                    end
                end
                StStart: begin
                    r_tx_start <= 1'b0;
                    r_state    <= StWaitBusy;
`ifdef UART_ARB_TIMEOUT_EN
                    r_tmo_cnt  <= '0;
`endif
                end
                StWaitBusy: begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (bus.uart_busy) begin
                        r_state <= StWaitDone;
                    end else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_ack         <= w_grant_onehot;
                        r_active      <= 1'b0;
                        r_state       <= StAck;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`else
                    if (bus.uart_busy) begin
                        r_state <= StWaitDone;
                    end
`endif
                end
                StWaitDone: begin
                    if (!bus.uart_busy) begin
                        r_ack    <= w_grant_onehot;
                        r_active <= 1'b0;
                        r_state  <= StAck;
                    end
                end
                StAck: begin
                    r_ack   <= '0;
                    r_ptr   <= r_grant;
                    r_state <= StIdle;
`ifdef UART_ARB_TIMEOUT_EN
                    r_timeout_err <= 1'b0;
`endif
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.ack           = r_ack;
    assign bus.grant_id      = r_grant;
    assign bus.active        = r_active;
    assign bus.uart_tx_start = r_tx_start;
    assign bus.uart_tx_data  = r_tx_data;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout_err   = r_timeout_err;
`else
    assign bus.timeout_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_top stand-in, ack scoreboard, vector table
// plus hand sequences for contention, withdraw, reset and start timeout.
module tb_uart_tx_arbiter;
    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned FRAME   = 10;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       terr;
    } exp_t;

    typedef struct packed {
        logic [3:0]      req;
        logic [31:0]     data;
        logic [2:0]      n;
        logic [3:0][1:0] ids;
    } vec_t;

    logic       clk;
    logic       rst;
    int         n_tests;
    int         n_fail;
    int         cyc;
    int         busy_fall_cyc;
    int         start_cyc;
    int         starts_since_ack;
    bit         uart_en;
    logic [3:0] rearm;
    logic [3:0] raise_next;
    logic [7:0] rearm_data [4];
    exp_t       sbq [$];
    logic [7:0] rxq [$];
    exp_t       mon_e;
    vec_t       vecs [8];

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_ack(input logic [1:0] id, input logic [7:0] d, input logic terr);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.terr = terr;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || bus.req != 0 || raise_next != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 1);
        if (n >= budget) begin
            sbq.delete();
            bus.req = '0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!bus.uart_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_seen", 32'(bus.uart_busy), 1);
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d, input logic [2:0] n,
                                input logic [1:0] i0, input logic [1:0] i1,
                                input logic [1:0] i2, input logic [1:0] i3);
        vec_t v;
        v.req    = r;
        v.data   = d;
        v.n      = n;
        v.ids[0] = i0;
        v.ids[1] = i1;
        v.ids[2] = i2;
        v.ids[3] = i3;
        return v;
    endfunction

    // uart_top stand-in: busy one cycle after start, FRAME cycles long, byte delivered at end.
    initial begin
        logic [7:0] cap;
        bit aborted;
        bus.uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && uart_en && bus.uart_tx_start === 1'b1) begin
                cap     = bus.uart_tx_data;
                aborted = 1'b0;
                @(negedge clk);
                bus.uart_busy = 1'b1;
                for (int i = 0; i < int'(FRAME); i++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                bus.uart_busy = 1'b0;
                busy_fall_cyc = cyc;
                if (!aborted) rxq.push_back(cap);
            end
        end
    end

    // Output monitor and scoreboard; also plays the requesters' release-on-ack.
    initial begin
        forever begin
            @(negedge clk);
            if (raise_next != 0) begin
                for (int k = 0; k < int'(N_REQ); k++) begin
                    if (raise_next[k]) begin
                        bus.req_data[k*8 +: 8] = rearm_data[k];
                        bus.req[k]             = 1'b1;
                    end
                end
                raise_next = '0;
            end
            if (!rst && bus.uart_tx_start === 1'b1) begin
                starts_since_ack++;
                start_cyc = cyc;
                if (sbq.size() > 0) begin
                    check("start_grant_id", 32'(bus.grant_id), 32'(sbq[0].id));
                    check("start_tx_data", 32'(bus.uart_tx_data), 32'(sbq[0].data));
                    check("start_active", 32'(bus.active), 1);
                end
            end
            if (!rst && bus.ack != 0 && !$isunknown(bus.ack)) begin
                check("ack_vs_start", 32'(bus.uart_tx_start), 0);
                check("ack_onehot", 32'($countones(bus.ack)), 1);
                check("ack_active", 32'(bus.active), 0);
                check("starts_per_frame", 32'(starts_since_ack), 1);
                starts_since_ack = 0;
                if (sbq.size() == 0) begin
                    check("ack_unexpected", 32'(bus.ack), 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("ack_vector", 32'(bus.ack), 32'(4'b0001 << mon_e.id));
                    check("ack_tx_data", 32'(bus.uart_tx_data), 32'(mon_e.data));
                    check("ack_timeout_err", 32'(bus.timeout_err), 32'(mon_e.terr));
                    if (mon_e.terr) begin
                        check("timeout_latency", 32'(cyc - start_cyc), 32'(TIMEOUT + 1));
                    end else begin
                        check("ack_latency", 32'(cyc - busy_fall_cyc), 1);
                        check("rx_count", 32'(rxq.size()), 1);
                        if (rxq.size() > 0) check("rx_data", 32'(rxq.pop_front()), 32'(mon_e.data));
                    end
                end
                for (int k = 0; k < int'(N_REQ); k++) begin
                    if (bus.ack[k]) begin
                        bus.req[k] = 1'b0;
                        if (rearm[k]) begin
                            rearm[k]      = 1'b0;
                            raise_next[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] dw;
        logic [1:0]  id;
        n_tests          = 0;
        n_fail           = 0;
        busy_fall_cyc    = 0;
        start_cyc        = 0;
        starts_since_ack = 0;
        uart_en          = 1'b1;
        rearm            = '0;
        raise_next       = '0;
        for (int k = 0; k < 4; k++) rearm_data[k] = '0;
        bus.req          = '0;
        bus.req_data     = '0;
        rst              = 1'b1;

        // Expected grant order hand-derived from the rr pointer left by the previous row.
        vecs[0] = mk(4'b0010, 32'h0000_A500, 3'd1, 2'd1, 2'd0, 2'd0, 2'd0);
        vecs[1] = mk(4'b1111, 32'hF00F_CCAA, 3'd4, 2'd2, 2'd3, 2'd0, 2'd1);
        vecs[2] = mk(4'b0101, 32'h0012_0034, 3'd2, 2'd2, 2'd0, 2'd0, 2'd0);
        vecs[3] = mk(4'b1010, 32'h5600_7800, 3'd2, 2'd1, 2'd3, 2'd0, 2'd0);
        vecs[4] = mk(4'b1001, 32'h9A00_00BC, 3'd2, 2'd0, 2'd3, 2'd0, 2'd0);
        vecs[5] = mk(4'b0100, 32'h00DE_0000, 3'd1, 2'd2, 2'd0, 2'd0, 2'd0);
        vecs[6] = mk(4'b0101, 32'h0021_0043, 3'd2, 2'd0, 2'd2, 2'd0, 2'd0);
        vecs[7] = mk(4'b1000, 32'h6500_0000, 3'd1, 2'd3, 2'd0, 2'd0, 2'd0);

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_active", 32'(bus.active), 0);
        check("rst_tx_start", 32'(bus.uart_tx_start), 0);
        check("rst_tx_data", 32'(bus.uart_tx_data), 0);
        check("rst_grant_id", 32'(bus.grant_id), 0);
        check("rst_timeout_err", 32'(bus.timeout_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: start pulse on the cycle after req is first seen in IDLE.
        bus.req_data[15:8] = 8'hA5;
        bus.req            = 4'b0010;
        expect_ack(2'd1, 8'hA5, 1'b0);
        @(negedge clk);
        check("lat_tx_start", 32'(bus.uart_tx_start), 1);
        check("lat_grant_id", 32'(bus.grant_id), 1);
        check("lat_active", 32'(bus.active), 1);
        wait_drain(400);

        for (int v = 0; v < 8; v++) begin
            dw = vecs[v].data;
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                id = vecs[v].ids[j];
                expect_ack(id, 8'(dw >> (8 * int'(id))), 1'b0);
            end
            bus.req_data = dw;
            bus.req      = vecs[v].req;
            wait_drain(1000);
        end

        // All held, requester 0 re-requests right after its ack: 0,1,2,3,0.
        bus.req_data  = 32'hF00F_CCAA;
        rearm[0]      = 1'b1;
        rearm_data[0] = 8'h5A;
        expect_ack(2'd0, 8'hAA, 1'b0);
        expect_ack(2'd1, 8'hCC, 1'b0);
        expect_ack(2'd2, 8'h0F, 1'b0);
        expect_ack(2'd3, 8'hF0, 1'b0);
        expect_ack(2'd0, 8'h5A, 1'b0);
        bus.req = 4'b1111;
        wait_drain(1500);

        // Winner withdraws and scribbles its data mid-frame; a non-winner arrives meanwhile.
        bus.req_data[15:8] = 8'h3C;
        bus.req            = 4'b0010;
        expect_ack(2'd1, 8'h3C, 1'b0);
        expect_ack(2'd2, 8'h66, 1'b0);
        wait_busy(50);
        @(negedge clk);
        bus.req[1]         = 1'b0;
        bus.req_data[15:8] = 8'h00;
        bus.req_data[23:16] = 8'h66;
        bus.req[2]         = 1'b1;
        wait_drain(600);

        // Reset during WAIT_DONE; afterwards the leftover frame keeps busy high.
        bus.req_data[23:16] = 8'h77;
        bus.req             = 4'b0100;
        wait_busy(50);
        @(negedge clk);
        rst              = 1'b1;
        bus.req          = '0;
        starts_since_ack = 0;
        @(negedge clk);
        check("midrst_ack", 32'(bus.ack), 0);
        check("midrst_active", 32'(bus.active), 0);
        check("midrst_tx_start", 32'(bus.uart_tx_start), 0);
        check("midrst_tx_data", 32'(bus.uart_tx_data), 0);
        check("midrst_grant_id", 32'(bus.grant_id), 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.req_data = 32'h0044_0033;
        bus.req      = 4'b0101;
        expect_ack(2'd0, 8'h33, 1'b0);
        expect_ack(2'd2, 8'h44, 1'b0);
        @(negedge clk);
        check("foreign_busy_level", 32'(bus.uart_busy), 1);
        check("foreign_busy_no_grant", 32'(bus.active), 0);
        check("foreign_busy_no_start", 32'(bus.uart_tx_start), 0);
        wait_drain(800);

        // Transmitter never answers the start pulse.
        uart_en             = 1'b0;
        bus.req_data[31:24] = 8'h99;
`ifdef UART_ARB_TIMEOUT_EN
        expect_ack(2'd3, 8'h99, 1'b1);
        bus.req = 4'b1000;
        wait_drain(200);
`else
        bus.req = 4'b1000;
        repeat (4 * TIMEOUT) @(negedge clk);
        check("stuck_active", 32'(bus.active), 1);
        check("stuck_ack", 32'(bus.ack), 0);
        check("stuck_timeout_err", 32'(bus.timeout_err), 0);
        rst              = 1'b1;
        bus.req          = '0;
        starts_since_ack = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        uart_en = 1'b1;

        bus.req_data[7:0] = 8'h5C;
        bus.req           = 4'b0001;
        expect_ack(2'd0, 8'h5C, 1'b0);
        wait_drain(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
